// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte-stream
// requesters, with per-packet grant lock and hold timeout.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned HOLD_TIMEOUT = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    input  logic [13:0]        divider_i,
    output logic [13:0]        divider_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_busy_i,
    output logic               timeout_o
);

    localparam int unsigned PW = $clog2(N_REQ);
    localparam logic [15:0] CNT_MAX = 16'(HOLD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ARB,
        START,
        WAIT_DONE,
        NEXT
    } state_e;

    state_e            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     gidx_q;
    logic [N_REQ-1:0]  grant_q;
    logic [7:0]        data_q;
    logic              last_q;
    logic [13:0]       div_q;
    logic              start_q;
    logic              timeout_q;
    logic [15:0]       cnt_q;

    logic [PW-1:0]     cand;
    logic [PW-1:0]     win_idx;
    logic              win_any;
    logic [N_REQ-1:0]  win_oh;
    logic [PW-1:0]     sel_idx;
    logic [7:0]        sel_data;
    logic              sel_last;
    logic              accept;
    logic [PW-1:0]     ptr_d;

    // Round-robin search for the first valid requester starting at ptr
    always_comb begin
        cand    = '0;
        win_idx = '0;
        win_any = 1'b0;
        for (int j = 0; j < int'(N_REQ); j++) begin
            cand = PW'((int'(ptr_q) + j) % int'(N_REQ));
            if (!win_any && req_valid_i[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
        win_oh = '0;
        if (win_any) begin
            win_oh[win_idx] = 1'b1;
        end
    end

    // Ready: winner in ARB, only the locked owner in NEXT, none otherwise
    always_comb begin
        req_ready_o = '0;
        case (state_q)
            ARB:     req_ready_o = win_oh;
            NEXT:    req_ready_o[gidx_q] = req_valid_i[gidx_q];
            default: req_ready_o = '0;
        endcase
    end

    // Byte/last selection from the requester being accepted
    always_comb begin
        sel_idx  = (state_q == ARB) ? win_idx : gidx_q;
        sel_data = req_data_i[{sel_idx, 3'b000} +: 8];
        sel_last = req_last_i[sel_idx];
        accept   = |(req_valid_i & req_ready_o);
        ptr_d    = PW'((int'(gidx_q) + 1) % int'(N_REQ));
    end

    // Sequencer: arbitration, start/busy handshake, packet lock and timeout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            gidx_q    <= '0;
            grant_q   <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            div_q     <= '0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ARB: begin
                    if (accept) begin
                        data_q  <= sel_data;
                        last_q  <= sel_last;
                        gidx_q  <= win_idx;
                        grant_q <= win_oh;
                        div_q   <= divider_i;
                        start_q <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tx_busy_i) begin
                        start_q <= 1'b0;
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        if (last_q) begin
                            grant_q <= '0;
                            ptr_q   <= ptr_d;
                            state_q <= ARB;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (accept) begin
                        data_q  <= sel_data;
                        last_q  <= sel_last;
                        start_q <= 1'b1;
                        state_q <= START;
                    end else if (cnt_q == CNT_MAX) begin
                        grant_q   <= '0;
                        ptr_q     <= ptr_d;
                        timeout_q <= 1'b1;
                        state_q   <= ARB;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign grant_o    = grant_q;
    assign divider_o  = div_q;
    assign tx_data_o  = data_q;
    assign tx_start_o = start_q;
    assign timeout_o  = timeout_q;

endmodule
